syn_av_mm_csr_slave: RTL and testbench
======================================

Name: syn_av_mm_csr_slave

Overview:
- Avalon-MM responder (slave end) for the testbench/CPU master side of the syn_av_mm bus: decodes av_read/av_write, owns a bank of RW config registers, exposes RO status words, returns read data with fixed pipelined latency.
- Sits at the end of every syn_av_mm bus segment feeding a Synesthesia datapath block; config registers drive the block, status inputs come back from it.

Parameters:
ADDR_W, 12, address width (word address)
DATA_W, 32, data width
NUM_REGS, 16, number of RW config registers (also number of RO status words); power of 2, 2*NUM_REGS <= 2**ADDR_W
RD_LAT, 2, cycles from sampled av_read to av_rd_data_valid; legal 1..8

Ports:
av_clk  in  1  bus clock; all logic on rising edge
av_rst  in  1  asynchronous, active-low reset
av_read  in  1  1 -> read transaction this cycle
av_write  in  1  1 -> write transaction this cycle
av_addr  in  ADDR_W  word address
av_write_data  in  DATA_W  write data
av_read_data  out  DATA_W  read data, qualified by av_rd_data_valid
av_rd_data_valid  out  1  1 -> av_read_data valid
cfg_regs_o  out  NUM_REGS*DATA_W  flat RW register contents, reg i at [i*DATA_W +: DATA_W]
cfg_wr_pulse_o  out  NUM_REGS  1-cycle pulse, cycle after reg i written
status_i  in  NUM_REGS*DATA_W  flat RO status words
err_cnt_o  out  16  saturating protocol/decode error count

Behaviour:
- Reset (av_rst low, async): all cfg regs 0, av_read_data 0, av_rd_data_valid 0, cfg_wr_pulse_o 0, err_cnt_o 0, read pipeline flushed. Reads in flight at reset assertion are dropped; no valid after release for them.
- Address map: 0..NUM_REGS-1 -> RW cfg reg; NUM_REGS..2*NUM_REGS-1 -> RO status_i[addr-NUM_REGS]; anything else -> unmapped.
- Write (av_write=1, av_read=0): RW address -> reg updated at that edge, visible on cfg_regs_o next cycle; cfg_wr_pulse_o[i]=1 for exactly that next cycle. Write to RO/unmapped -> no state change, err_cnt_o+1.
- Read (av_read=1, av_write=0): data captured at the sampling edge (cfg reg value before any later write; status_i sampled that edge). av_rd_data_valid=1 with data exactly RD_LAT cycles after the sampling edge. Unmapped read returns 0, still asserts valid, err_cnt_o+1.
- Fully pipelined: one read accepted per cycle, back-to-back reads give back-to-back valids in order; no backpressure, no waitrequest.
- Write at cycle N, read same address at N+1 -> returns new value.
- av_read and av_write both 1: write performed per rules above, read ignored (no valid generated), err_cnt_o+1 (once per cycle, even if write also illegal).
- av_read_data is 0 whenever av_rd_data_valid=0.
- err_cnt_o saturates at 16'hFFFF; no wrap.
- Address bits above decoded range must be zero for a mapped hit; otherwise unmapped.

Decomposition:
- Package syn_av_mm_csr_pkg: RD_LAT_MAX=8, ERR_CNT_W=16, typedef enum for decode result {DEC_RW, DEC_RO, DEC_UNMAPPED}, function computing decode from addr/NUM_REGS.
- Sub-module syn_av_mm_rd_pipe: RD_LAT-deep shift register of {valid, data}, async active-low reset, zeroing data when valid low.

Test Plan:
- Reset then read addr 0..15 -> 16 valids, each RD_LAT=2 cycles after read, all data 0, err_cnt_o=0.
- Write 0xA5A5_0001 to addr 3, read addr 3 next cycle -> cfg_wr_pulse_o=16'h0008 for one cycle, read returns 0xA5A5_0001 two cycles after read.
- Drive status_i word 5 = 0x1234_5678, read addr 21 (NUM_REGS+5) -> 0x1234_5678; write addr 21 -> no change, err_cnt_o=1.
- 8 back-to-back reads addr 0..7 with distinct preloaded values -> 8 contiguous valid cycles, in-order data; repeat with RD_LAT=1 and 8.
- av_read=av_write=1 addr 2 data 0xFF -> reg 2=0xFF, no valid, err_cnt_o+1; read addr 40 -> valid with 0, err_cnt_o+1.
- Issue 2 reads, assert av_rst low one cycle after -> no valid ever appears, all outputs 0; 70000 unmapped writes -> err_cnt_o holds 0xFFFF.

Source files
------------

// File: rtl/syn_av_mm_csr_pkg.sv
// Shared constants, decode result type and address decode helper for the
// syn_av_mm CSR responder.
package syn_av_mm_csr_pkg;

   localparam int RD_LAT_MAX = 8;
   localparam int ERR_CNT_W  = 16;

   typedef enum logic [1:0] {
      DEC_RW,
      DEC_RO,
      DEC_UNMAPPED
   } dec_e;

   // The full-width compare makes any nonzero upper address bit fall through to unmapped.
   function automatic dec_e decode_addr(input logic [31:0] addr, input int unsigned num_regs);
      if (addr < num_regs)
         return DEC_RW;
      else if (addr < 2 * num_regs)
         return DEC_RO;
      else
         return DEC_UNMAPPED;
   endfunction

endpackage

// File: rtl/syn_av_mm_rd_pipe.sv
// Fixed-latency read return pipe: RD_LAT stages of {valid, data}. A stage's
// data is zero whenever its valid is low.
module syn_av_mm_rd_pipe #(
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              vld_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              vld_o,
   output logic [DATA_W-1:0] data_o
);

   logic [RD_LAT-1:0]             vld_q;
   logic [RD_LAT-1:0][DATA_W-1:0] data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q  <= '0;
         data_q <= '0;
      end else begin
         vld_q[0]  <= vld_i;
         data_q[0] <= vld_i ? data_i : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            data_q[i] <= data_q[i-1];
         end
      end
   end

   assign vld_o  = vld_q[RD_LAT-1];
   assign data_o = data_q[RD_LAT-1];

endmodule

// File: rtl/syn_av_mm_csr_slave.sv
// Avalon-MM CSR responder: RW config bank, RO status window, pipelined
// fixed-latency reads and a saturating protocol/decode error counter.
module syn_av_mm_csr_slave
   import syn_av_mm_csr_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int RD_LAT   = 2
) (
   input  logic                       av_clk,
   input  logic                       av_rst,
   input  logic                       av_read,
   input  logic                       av_write,
   input  logic [ADDR_W-1:0]          av_addr,
   input  logic [DATA_W-1:0]          av_write_data,
   output logic [DATA_W-1:0]          av_read_data,
   output logic                       av_rd_data_valid,
   output logic [NUM_REGS*DATA_W-1:0] cfg_regs_o,
   output logic [NUM_REGS-1:0]        cfg_wr_pulse_o,
   input  logic [NUM_REGS*DATA_W-1:0] status_i,
   output logic [ERR_CNT_W-1:0]       err_cnt_o
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [NUM_REGS-1:0][DATA_W-1:0] cfg_q, cfg_d;
   logic [NUM_REGS-1:0][DATA_W-1:0] status_w;
   logic [NUM_REGS-1:0]             pulse_q, pulse_d;
   logic [ERR_CNT_W-1:0]            err_q, err_d;
   logic [IDX_W-1:0]                idx;
   dec_e                            dec;
   logic                            wr_hit, rd_vld, err_inc;
   logic [DATA_W-1:0]               rd_data;

   assign status_w = status_i;
   assign dec      = decode_addr(32'(av_addr), NUM_REGS);
   assign idx      = av_addr[IDX_W-1:0];
   assign wr_hit   = av_write && (dec == DEC_RW);
   // A write wins a read/write collision; the read is discarded.
   assign rd_vld   = av_read && !av_write;
   // At most one error per cycle, however many rules the cycle breaks.
   assign err_inc  = (av_read && av_write)
                   || (av_write && (dec != DEC_RW))
                   || (av_read && (dec == DEC_UNMAPPED));

   always_comb begin
      cfg_d   = cfg_q;
      pulse_d = '0;
      if (wr_hit) begin
         cfg_d[idx]   = av_write_data;
         pulse_d[idx] = 1'b1;
      end
   end

   always_comb begin
      err_d = err_q;
      if (err_inc && (err_q != '1))
         err_d = err_q + 1'b1;
   end

   always_comb begin
      rd_data = '0;
      case (dec)
         DEC_RW:  rd_data = cfg_q[idx];
         DEC_RO:  rd_data = status_w[idx];
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge av_clk or negedge av_rst) begin
      if (!av_rst) begin
         cfg_q   <= '0;
         pulse_q <= '0;
         err_q   <= '0;
      end else begin
         cfg_q   <= cfg_d;
         pulse_q <= pulse_d;
         err_q   <= err_d;
      end
   end

   syn_av_mm_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk_i  (av_clk),
      .rst_ni (av_rst),
      .vld_i  (rd_vld),
      .data_i (rd_data),
      .vld_o  (av_rd_data_valid),
      .data_o (av_read_data)
   );

   assign cfg_regs_o     = cfg_q;
   assign cfg_wr_pulse_o = pulse_q;
   assign err_cnt_o      = err_q;

endmodule

// File: tb/tb_syn_av_mm_csr_slave.sv
// Directed bench: a vector table on the RD_LAT=2 instance, plus hand sequences
// for back-to-back reads at RD_LAT 1/2/8, reset while reads are in flight and
// saturation of the error counter.
module tb_syn_av_mm_csr_slave;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int NR = 16;

   logic                 av_clk = 1'b0;
   logic                 av_rst;
   logic                 av_read, av_write;
   logic [AW-1:0]        av_addr;
   logic [DW-1:0]        av_write_data;
   logic [NR*DW-1:0]     status_i;

   logic [DW-1:0]        rdata2, rdata1, rdata8;
   logic                 vld2, vld1, vld8;
   logic [NR*DW-1:0]     cfg2, cfg1, cfg8;
   logic [NR-1:0]        pls2, pls1, pls8;
   logic [15:0]          err2, err1, err8;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 av_clk = ~av_clk;

   syn_av_mm_csr_slave #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .RD_LAT(2)) u_dut (
      .av_clk(av_clk), .av_rst(av_rst), .av_read(av_read), .av_write(av_write),
      .av_addr(av_addr), .av_write_data(av_write_data), .av_read_data(rdata2),
      .av_rd_data_valid(vld2), .cfg_regs_o(cfg2), .cfg_wr_pulse_o(pls2),
      .status_i(status_i), .err_cnt_o(err2));

   syn_av_mm_csr_slave #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .RD_LAT(1)) u_dut_l1 (
      .av_clk(av_clk), .av_rst(av_rst), .av_read(av_read), .av_write(av_write),
      .av_addr(av_addr), .av_write_data(av_write_data), .av_read_data(rdata1),
      .av_rd_data_valid(vld1), .cfg_regs_o(cfg1), .cfg_wr_pulse_o(pls1),
      .status_i(status_i), .err_cnt_o(err1));

   syn_av_mm_csr_slave #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .RD_LAT(8)) u_dut_l8 (
      .av_clk(av_clk), .av_rst(av_rst), .av_read(av_read), .av_write(av_write),
      .av_addr(av_addr), .av_write_data(av_write_data), .av_read_data(rdata8),
      .av_rd_data_valid(vld8), .cfg_regs_o(cfg8), .cfg_wr_pulse_o(pls8),
      .status_i(status_i), .err_cnt_o(err8));

   typedef struct {
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic          ev;
      logic [DW-1:0] ed;
      logic [NR-1:0] ep;
      logic [15:0]   ee;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic ev, input logic [DW-1:0] ed,
                      input logic [NR-1:0] ep, input logic [15:0] ee);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd;
      v.ev = ev; v.ed = ed; v.ep = ep; v.ee = ee;
      tbl.push_back(v);
   endtask

   task automatic idle(input logic ev, input logic [DW-1:0] ed, input logic [15:0] ee);
      add(1'b0, 1'b0, '0, '0, ev, ed, '0, ee);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge av_clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
      av_read = rd; av_write = wr; av_addr = a; av_write_data = wd;
   endtask

   task automatic chk_pipe(input string nm, input int lat, input int k,
                           input logic v, input logic [DW-1:0] d,
                           input logic [DW-1:0] pre [8]);
      logic          ev;
      logic [DW-1:0] ed;
      ev = (k >= lat - 1) && (k < lat - 1 + 8);
      ed = ev ? pre[k-lat+1] : '0;
      chk($sformatf("%s k%0d vld", nm, k), 64'(v), 64'(ev));
      chk($sformatf("%s k%0d data", nm, k), 64'(d), 64'(ed));
   endtask

   initial begin
      logic [DW-1:0] pre [8];

      av_rst = 1'b0;
      drive(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < NR; i++) status_i[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
      status_i[5*DW +: DW] = 32'h1234_5678;

      // vector table, expectations for the RD_LAT=2 instance sampled after each edge
      for (int j = 0; j < NR; j++) add(1'b1, 1'b0, AW'(j), '0, (j >= 1), '0, '0, 16'd0);
      idle(1'b1, '0, 16'd0);
      idle(1'b0, '0, 16'd0);
      add(1'b0, 1'b1, 12'd3, 32'hA5A5_0001, 1'b0, '0, 16'h0008, 16'd0);
      add(1'b1, 1'b0, 12'd3, '0, 1'b0, '0, '0, 16'd0);
      idle(1'b1, 32'hA5A5_0001, 16'd0);
      idle(1'b0, '0, 16'd0);
      add(1'b1, 1'b0, 12'd21, '0, 1'b0, '0, '0, 16'd0);
      idle(1'b1, 32'h1234_5678, 16'd0);
      add(1'b0, 1'b1, 12'd21, 32'hDEAD, 1'b0, '0, '0, 16'd1);
      add(1'b1, 1'b0, 12'd31, '0, 1'b0, '0, '0, 16'd1);
      add(1'b1, 1'b0, 12'd21, '0, 1'b1, 32'hC0DE_000F, '0, 16'd1);
      idle(1'b1, 32'h1234_5678, 16'd1);
      idle(1'b0, '0, 16'd1);
      add(1'b1, 1'b1, 12'd2, 32'hFF, 1'b0, '0, 16'h0004, 16'd2);
      idle(1'b0, '0, 16'd2);
      add(1'b1, 1'b0, 12'd2, '0, 1'b0, '0, '0, 16'd2);
      add(1'b1, 1'b0, 12'd40, '0, 1'b1, 32'hFF, '0, 16'd3);
      add(1'b1, 1'b0, 12'd32, '0, 1'b1, '0, '0, 16'd4);
      add(1'b1, 1'b0, 12'h803, '0, 1'b1, '0, '0, 16'd5);
      add(1'b1, 1'b0, 12'd15, '0, 1'b1, '0, '0, 16'd5);
      idle(1'b1, '0, 16'd5);
      idle(1'b0, '0, 16'd5);
      add(1'b0, 1'b1, 12'h802, 32'h1, 1'b0, '0, '0, 16'd6);
      add(1'b1, 1'b0, 12'd2, '0, 1'b0, '0, '0, 16'd6);
      idle(1'b1, 32'hFF, 16'd6);
      idle(1'b0, '0, 16'd6);

      tick(); tick();
      chk("reset vld", 64'(vld2), 64'd0);
      chk("reset rdata", 64'(rdata2), 64'd0);
      chk("reset err", 64'(err2), 64'd0);
      chk("reset cfg", 64'(|cfg2), 64'd0);
      av_rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd);
         tick();
         chk($sformatf("vec%0d vld", i),   64'(vld2),   64'(tbl[i].ev));
         chk($sformatf("vec%0d rdata", i), 64'(rdata2), 64'(tbl[i].ed));
         chk($sformatf("vec%0d pulse", i), 64'(pls2),   64'(tbl[i].ep));
         chk($sformatf("vec%0d err", i),   64'(err2),   64'(tbl[i].ee));
      end
      chk("cfg reg3", 64'(cfg2[3*DW +: DW]), 64'h0000_0000_A5A5_0001);
      chk("cfg reg2", 64'(cfg2[2*DW +: DW]), 64'h0000_0000_0000_00FF);
      chk("cfg reg5", 64'(cfg2[5*DW +: DW]), 64'd0);
      chk("err lat1", 64'(err1), 64'd6);

      // drain the RD_LAT=8 pipe, then preload regs 0..7 and read them back-to-back
      drive(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 10; i++) tick();
      for (int i = 0; i < 8; i++) begin
         pre[i] = 32'h1000_0000 + 32'(i) * 32'h111;
         drive(1'b0, 1'b1, AW'(i), pre[i]);
         tick();
         chk($sformatf("preload pulse %0d", i), 64'(pls2), 64'(16'd1 << i));
      end
      for (int k = 0; k < 20; k++) begin
         if (k < 8) drive(1'b1, 1'b0, AW'(k), '0);
         else       drive(1'b0, 1'b0, '0, '0);
         tick();
         chk_pipe("b2b lat1", 1, k, vld1, rdata1, pre);
         chk_pipe("b2b lat2", 2, k, vld2, rdata2, pre);
         chk_pipe("b2b lat8", 8, k, vld8, rdata8, pre);
      end
      chk("err lat8", 64'(err8), 64'd6);

      // reset while reads are in flight
      drive(1'b1, 1'b0, 12'd3, '0);
      tick(); tick();
      drive(1'b0, 1'b0, '0, '0);
      av_rst = 1'b0;
      #1;
      chk("inrst vld lat2", 64'(vld2), 64'd0);
      chk("inrst vld lat8", 64'(vld8), 64'd0);
      chk("inrst rdata lat8", 64'(rdata8), 64'd0);
      chk("inrst cfg lat8", 64'(|cfg8), 64'd0);
      chk("inrst cfg lat1", 64'(|cfg1), 64'd0);
      chk("inrst pulse", 64'({pls1, pls2, pls8}), 64'd0);
      chk("inrst err", 64'(err2), 64'd0);
      tick(); tick();
      av_rst = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk($sformatf("postrst k%0d vld", k), 64'({vld1, vld2, vld8}), 64'd0);
      end

      // error counter saturation
      drive(1'b0, 1'b1, 12'd40, 32'h5);
      for (int i = 0; i < 65534; i++) tick();
      chk("err 65534", 64'(err2), 64'hFFFE);
      tick();
      chk("err 65535", 64'(err2), 64'hFFFF);
      for (int i = 0; i < 70000 - 65535; i++) tick();
      drive(1'b0, 1'b0, '0, '0);
      chk("err sat", 64'(err2), 64'hFFFF);
      chk("err sat lat8", 64'(err8), 64'hFFFF);
      chk("sat cfg", 64'(|cfg2), 64'd0);
      chk("sat pulse", 64'(pls2), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
